// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST signature checker:
//   - default widths and MISR feedback polynomial
//   - checker FSM state encoding
//   - misr_step(): one MISR compression step, width-generic up to 63 bits
// No ports (package).
// -----------------------------------------------------------------------------
package bist_pkg;

   localparam int unsigned MISR_WIDTH_DEF = 16;
   localparam int unsigned IN_WIDTH_DEF   = 4;
   localparam int unsigned CNT_WIDTH_DEF  = 16;
   localparam logic [15:0] POLY_DEF       = 16'h1021;

   // Working width of misr_step(); callers zero-extend into it and truncate back.
   localparam int unsigned STEP_MAX_W     = 64;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COMPRESS,
      DONE
   } chk_state_e;

   // next = (sig << 1) ^ (msb ? poly : 0) ^ din, limited to 'width' bits.
   // Masking the result also discards any poly bits above 'width'.
   function automatic logic [STEP_MAX_W-1:0] misr_step(
      input logic [STEP_MAX_W-1:0] sig,
      input logic [STEP_MAX_W-1:0] poly,
      input logic [STEP_MAX_W-1:0] din,
      input int unsigned           width
   );
      logic [STEP_MAX_W-1:0] mask;
      logic [STEP_MAX_W-1:0] nxt;
      logic                  msb;
      mask = (STEP_MAX_W'(1) << width) - STEP_MAX_W'(1);
      msb  = |(sig & (STEP_MAX_W'(1) << (width - 1)));
      nxt  = (sig << 1) ^ din;
      if (msb) begin
         nxt = nxt ^ poly;
      end
      return nxt & mask;
   endfunction

endpackage

// File: rtl/bist_signature_checker_if.sv
// -----------------------------------------------------------------------------
// bist_signature_checker_if
// Groups the BIST controller / scan inputs and the checker result outputs.
//   init, running, finish, mode : controller control signals
//   scan_out                    : parallel scan-chain outputs (IN_WIDTH)
//   signature                   : current MISR contents (MISR_WIDTH)
//   cycle_count                 : compress cycles since init (CNT_WIDTH)
//   result_valid, pass, fail    : compare result
// Modports: master = controller/observer side, slave = checker side.
// -----------------------------------------------------------------------------
interface bist_signature_checker_if
   import bist_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF,
   parameter int unsigned MISR_WIDTH = MISR_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
);

   logic                  init;
   logic                  running;
   logic                  finish;
   logic                  mode;
   logic [IN_WIDTH-1:0]   scan_out;
   logic [MISR_WIDTH-1:0] signature;
   logic [CNT_WIDTH-1:0]  cycle_count;
   logic                  result_valid;
   logic                  pass;
   logic                  fail;

   modport master (
      output init, running, finish, mode, scan_out,
      input  signature, cycle_count, result_valid, pass, fail
   );

   modport slave (
      input  init, running, finish, mode, scan_out,
      output signature, cycle_count, result_valid, pass, fail
   );

endinterface

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, loads SEED
//   load_i : load SEED (priority over en_i)
//   en_i   : apply one compression step with din_i
//   din_i  : parallel input bits, zero-extended into the register
//   sig_o  : register contents
// -----------------------------------------------------------------------------
module bist_misr
   import bist_pkg::*;
#(
   parameter int unsigned      WIDTH    = MISR_WIDTH_DEF,
   parameter int unsigned      IN_WIDTH = IN_WIDTH_DEF,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(POLY_DEF),
   parameter logic [WIDTH-1:0] SEED     = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic                en_i,
   input  logic [IN_WIDTH-1:0] din_i,
   output logic [WIDTH-1:0]    sig_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load_i) begin
         sig_d = SEED;
      end else if (en_i) begin
         sig_d = WIDTH'(misr_step(STEP_MAX_W'(sig_q), STEP_MAX_W'(POLY),
                                  STEP_MAX_W'(din_i), WIDTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/bist_signature_checker.sv
// -----------------------------------------------------------------------------
// bist_signature_checker
// Compresses scan-out data into a MISR while the BIST controller runs, then
// compares the signature with GOLDEN_SIG on finish and holds pass/fail until
// the next init or reset.
//   clock : system clock (rising edge)
//   reset : synchronous active-high reset
//   chk   : slave modport of bist_signature_checker_if
//           (init/running/finish/mode/scan_out in;
//            signature/cycle_count/result_valid/pass/fail out)
// Optional build macro BIST_SIG_CYCLE_CHECK_EN: pass also requires
// cycle_count == EXPECTED_CYCLES.
// -----------------------------------------------------------------------------
module bist_signature_checker
   import bist_pkg::*;
#(
   parameter int unsigned           MISR_WIDTH      = MISR_WIDTH_DEF,
   parameter int unsigned           IN_WIDTH        = IN_WIDTH_DEF,
   parameter logic [MISR_WIDTH-1:0] POLY            = MISR_WIDTH'(POLY_DEF),
   parameter logic [MISR_WIDTH-1:0] SEED            = '0,
   parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG      = '0,
   parameter int unsigned           CNT_WIDTH       = CNT_WIDTH_DEF,
   parameter logic [CNT_WIDTH-1:0]  EXPECTED_CYCLES = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   bist_signature_checker_if.slave  chk
);

   chk_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  rv_q, rv_d;
   logic                  pass_q, pass_d;
   logic                  fail_q, fail_d;
   logic                  misr_load;
   logic                  misr_en;
   logic [MISR_WIDTH-1:0] sig;
   logic                  sig_match;
   logic                  cnt_match;
   logic                  result_ok;

   bist_misr #(
      .WIDTH    (MISR_WIDTH),
      .IN_WIDTH (IN_WIDTH),
      .POLY     (POLY),
      .SEED     (SEED)
   ) u_misr (
      .clk_i  (clock),
      .rst_i  (reset),
      .load_i (misr_load),
      .en_i   (misr_en),
      .din_i  (chk.scan_out),
      .sig_o  (sig)
   );

   // Compare uses the registered signature, so a compress requested on the
   // finish edge never reaches the result.
   assign sig_match = (sig == GOLDEN_SIG);
   assign cnt_match = (cnt_q == EXPECTED_CYCLES);

`ifdef BIST_SIG_CYCLE_CHECK_EN
   assign result_ok = sig_match & cnt_match;
`else
   logic unused_cnt_match;
   assign unused_cnt_match = cnt_match;
   assign result_ok        = sig_match;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rv_d      = rv_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      // init wins over finish and compress in every state.
      if (chk.init) begin
         state_d   = ARMED;
         misr_load = 1'b1;
         cnt_d     = '0;
         rv_d      = 1'b0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED, COMPRESS: begin
               if (chk.finish) begin
                  state_d = DONE;
                  rv_d    = 1'b1;
                  pass_d  = result_ok;
                  fail_d  = ~result_ok;
               end else if (chk.running && chk.mode) begin
                  state_d = COMPRESS;
                  misr_en = 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rv_q    <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign chk.signature    = sig;
   assign chk.cycle_count  = cnt_q;
   assign chk.result_valid = rv_q;
   assign chk.pass         = pass_q;
   assign chk.fail         = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// -----------------------------------------------------------------------------
// tb_bist_signature_checker
// Four checker instances share one stimulus stream:
//   u0 SEED 0,      GOLDEN 0x0011, EXPECTED_CYCLES 3
//   u1 SEED 0,      GOLDEN 0x0012, EXPECTED_CYCLES 2
//   u2 SEED 0x8000, GOLDEN 0x2053, EXPECTED_CYCLES 2 (feedback path)
//   u3 SEED 0,      GOLDEN 0x0000, 2-bit counter, EXPECTED_CYCLES 3
// Stimulus pushes hand-computed expectations into a queue; a negedge monitor
// pops and compares them against the outputs.
// -----------------------------------------------------------------------------
module tb_bist_signature_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       init;
   logic       running;
   logic       finish;
   logic       mode;
   logic [3:0] scan_out;

   always #5 clk = ~clk;

   bist_signature_checker_if #(.IN_WIDTH(4), .MISR_WIDTH(16), .CNT_WIDTH(16)) if0 ();
   bist_signature_checker_if #(.IN_WIDTH(4), .MISR_WIDTH(16), .CNT_WIDTH(16)) if1 ();
   bist_signature_checker_if #(.IN_WIDTH(4), .MISR_WIDTH(16), .CNT_WIDTH(16)) if2 ();
   bist_signature_checker_if #(.IN_WIDTH(4), .MISR_WIDTH(16), .CNT_WIDTH(2))  if3 ();

   assign {if0.init, if0.running, if0.finish, if0.mode, if0.scan_out} = {init, running, finish, mode, scan_out};
   assign {if1.init, if1.running, if1.finish, if1.mode, if1.scan_out} = {init, running, finish, mode, scan_out};
   assign {if2.init, if2.running, if2.finish, if2.mode, if2.scan_out} = {init, running, finish, mode, scan_out};
   assign {if3.init, if3.running, if3.finish, if3.mode, if3.scan_out} = {init, running, finish, mode, scan_out};

   bist_signature_checker #(
      .MISR_WIDTH(16), .IN_WIDTH(4), .POLY(16'h1021), .SEED(16'h0000),
      .GOLDEN_SIG(16'h0011), .CNT_WIDTH(16), .EXPECTED_CYCLES(16'd3)
   ) u0 (.clock(clk), .reset(rst), .chk(if0));

   bist_signature_checker #(
      .MISR_WIDTH(16), .IN_WIDTH(4), .POLY(16'h1021), .SEED(16'h0000),
      .GOLDEN_SIG(16'h0012), .CNT_WIDTH(16), .EXPECTED_CYCLES(16'd2)
   ) u1 (.clock(clk), .reset(rst), .chk(if1));

   bist_signature_checker #(
      .MISR_WIDTH(16), .IN_WIDTH(4), .POLY(16'h1021), .SEED(16'h8000),
      .GOLDEN_SIG(16'h2053), .CNT_WIDTH(16), .EXPECTED_CYCLES(16'd2)
   ) u2 (.clock(clk), .reset(rst), .chk(if2));

   bist_signature_checker #(
      .MISR_WIDTH(16), .IN_WIDTH(4), .POLY(16'h1021), .SEED(16'h0000),
      .GOLDEN_SIG(16'h0000), .CNT_WIDTH(2), .EXPECTED_CYCLES(2'd3)
   ) u3 (.clock(clk), .reset(rst), .chk(if3));

   typedef struct {
      int unsigned dut;
      string       name;
      logic [15:0] sig;
      logic [15:0] cnt;
      logic        rv;
      logic        ps;
      logic        fl;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   // ---------------- monitor ----------------
   exp_t        sb_e;
   logic [15:0] a_sig;
   logic [15:0] a_cnt;
   logic        a_rv, a_ps, a_fl;

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         sb_e = sb_q.pop_front();
         case (sb_e.dut)
            0: begin a_sig = if0.signature; a_cnt = if0.cycle_count; a_rv = if0.result_valid; a_ps = if0.pass; a_fl = if0.fail; end
            1: begin a_sig = if1.signature; a_cnt = if1.cycle_count; a_rv = if1.result_valid; a_ps = if1.pass; a_fl = if1.fail; end
            2: begin a_sig = if2.signature; a_cnt = if2.cycle_count; a_rv = if2.result_valid; a_ps = if2.pass; a_fl = if2.fail; end
            default: begin a_sig = if3.signature; a_cnt = 16'(if3.cycle_count); a_rv = if3.result_valid; a_ps = if3.pass; a_fl = if3.fail; end
         endcase
         tests++;
         if ({a_sig, a_cnt, a_rv, a_ps, a_fl} !== {sb_e.sig, sb_e.cnt, sb_e.rv, sb_e.ps, sb_e.fl}) begin
            fails++;
            $display("FAIL %s[u%0d]: got sig=%h cnt=%0d rv=%b pass=%b fail=%b, want sig=%h cnt=%0d rv=%b pass=%b fail=%b",
                     sb_e.name, sb_e.dut, a_sig, a_cnt, a_rv, a_ps, a_fl,
                     sb_e.sig, sb_e.cnt, sb_e.rv, sb_e.ps, sb_e.fl);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic r, input logic i, input logic ru,
                        input logic f, input logic m, input logic [3:0] s);
      rst      = r;
      init     = i;
      running  = ru;
      finish   = f;
      mode     = m;
      scan_out = s;
      @(posedge clk);
      #1;
   endtask

   // sa: u0/u1/u3 signature, sb: u2 signature, c: u0-u2 count, c3: u3 count.
   // pv/fv bit k = expected pass/fail of instance uk.
   task automatic expect_all(input string n, input logic [15:0] sa, input logic [15:0] sb,
                             input logic [15:0] c, input logic [15:0] c3, input logic rv,
                             input logic [3:0] pv, input logic [3:0] fv);
      exp_t e;
      for (int unsigned k = 0; k < 4; k++) begin
         e.dut  = k;
         e.name = n;
         e.sig  = (k == 2) ? sb : sa;
         e.cnt  = (k == 3) ? c3 : c;
         e.rv   = rv;
         e.ps   = pv[k];
         e.fl   = fv[k];
         sb_q.push_back(e);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      drive(1, 0, 0, 0, 0, 4'h0);
      drive(1, 0, 0, 0, 0, 4'h0);
      expect_all("reset", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      // finish / running without prior init are ignored
      drive(0, 0, 0, 1, 0, 4'h0);
      drive(0, 0, 1, 0, 1, 4'hA);
      expect_all("no_init", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      drive(0, 1, 0, 0, 0, 4'h0);
      expect_all("init", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 1, 0, 1, 4'hA);
      expect_all("cmp_A", 16'h000A, 16'h102B, 16'd1, 16'd1, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 1, 0, 0, 4'hF);
      expect_all("capture_hold", 16'h000A, 16'h102B, 16'd1, 16'd1, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 1, 0, 1, 4'h5);
      expect_all("cmp_5", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b0, 4'b0000, 4'b0000);

      // finish with a simultaneous compress request: compress excluded
      drive(0, 0, 1, 1, 1, 4'hF);
`ifdef BIST_SIG_CYCLE_CHECK_EN
      expect_all("finish1", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b1, 4'b0100, 4'b1011);
`else
      expect_all("finish1", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b1, 4'b0101, 4'b1010);
`endif

      drive(0, 0, 1, 0, 1, 4'h3);
`ifdef BIST_SIG_CYCLE_CHECK_EN
      expect_all("done_hold", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b1, 4'b0100, 4'b1011);
`else
      expect_all("done_hold", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b1, 4'b0101, 4'b1010);
`endif

      drive(0, 1, 0, 0, 0, 4'h0);
      expect_all("reinit", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 1, 0, 1, 4'h1);
      drive(0, 0, 1, 0, 1, 4'h2);
      drive(0, 0, 1, 0, 1, 4'h3);
      expect_all("cmp_123", 16'h0003, 16'h4087, 16'd3, 16'd3, 1'b0, 4'b0000, 4'b0000);

      // reset overrides init/finish/compress
      drive(1, 1, 1, 1, 1, 4'hF);
      expect_all("reset_mid", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      drive(0, 1, 0, 0, 0, 4'h0);
      drive(0, 0, 1, 0, 1, 4'hA);
      drive(0, 0, 1, 0, 1, 4'h5);
      expect_all("post_reset", 16'h0011, 16'h2053, 16'd2, 16'd2, 1'b0, 4'b0000, 4'b0000);

      // init from COMPRESS reloads seed; 4,0,1 reaches 0x0011 in 3 cycles
      drive(0, 1, 0, 0, 0, 4'h0);
      drive(0, 0, 1, 0, 1, 4'h4);
      drive(0, 0, 1, 0, 1, 4'h0);
      drive(0, 0, 1, 0, 1, 4'h1);
      expect_all("cmp_401", 16'h0011, 16'h4095, 16'd3, 16'd3, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 0, 1, 0, 4'h0);
      expect_all("finish2", 16'h0011, 16'h4095, 16'd3, 16'd3, 1'b1, 4'b0001, 4'b1110);

      // five zero compresses: u3 counter saturates at 3
      drive(0, 1, 0, 0, 0, 4'h0);
      for (int unsigned k = 0; k < 5; k++) begin
         drive(0, 0, 1, 0, 1, 4'h0);
      end
      expect_all("saturate", 16'h0000, 16'h1231, 16'd5, 16'd3, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 0, 1, 0, 4'h0);
      expect_all("finish3", 16'h0000, 16'h1231, 16'd5, 16'd3, 1'b1, 4'b1000, 4'b0111);

      // init beats a simultaneous finish
      drive(0, 1, 0, 1, 0, 4'h0);
      expect_all("init_vs_finish", 16'h0000, 16'h8000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);

      drive(0, 0, 0, 0, 0, 4'h0);
      @(negedge clk);
      #1;
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bist_signature_checker.md
Name: bist_signature_checker

Overview:
- Downstream consumer of the BIST controller (init/running/finish/mode) and of the circuit-under-test scan outputs.
- Compresses scan-out data into a multiple-input signature register (MISR) while the controller runs.
- On finish, compares the signature against a golden value and reports pass/fail until the next init or reset.
- Its result feeds the chip-level BIST status.

Parameters:
- MISR_WIDTH, 16, signature register width (≥ IN_WIDTH, ≥ 2).
- IN_WIDTH, 4, number of parallel scan-out bits compressed per cycle.
- POLY, 16'h1021, feedback polynomial XORed in when MSB is 1 (bits above MISR_WIDTH ignored).
- SEED, 16'h0000, value loaded into the MISR on init.
- GOLDEN_SIG, 16'h0000, expected final signature.
- CNT_WIDTH, 16, width of the compress-cycle counter.
- EXPECTED_CYCLES, 0, expected compress-cycle count; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  controller init pulse; arms the checker.
- running  in  1  controller running level.
- finish  in  1  controller finish pulse; triggers compare.
- mode  in  1  scan mode from controller; 1 = shift/compress.
- scan_out  in  IN_WIDTH  parallel scan-chain outputs.
- signature  out  MISR_WIDTH  current MISR contents.
- cycle_count  out  CNT_WIDTH  number of compress cycles since init.
- result_valid  out  1  high while pass/fail is valid.
- pass  out  1  signature matched (qualified by result_valid).
- fail  out  1  signature mismatched (qualified by result_valid).

Behaviour:
- Reset (synchronous, sampled at the rising edge, any state): state=IDLE, signature=SEED, cycle_count=0, result_valid=0, pass=0, fail=0. Reset overrides every other input.
- FSM states: IDLE, ARMED, COMPRESS, DONE.
  - IDLE: init → ARMED. running and finish are ignored, so no result is produced without a prior init.
  - ARMED: signature=SEED, cycle_count=0, result_valid/pass/fail=0. running&mode → COMPRESS; the compress happens on that same edge.
  - COMPRESS: every edge with running&mode=1 applies one MISR step:
    - next = (sig<<1)[MISR_WIDTH-1:0] ^ (sig[MISR_WIDTH-1] ? POLY : 0) ^ zero-extended scan_out.
    - cycle_count increments and saturates at all-ones.
    - running=1 with mode=0 (capture cycle) holds signature and count.
  - finish (in ARMED or COMPRESS): compare registered signature to GOLDEN_SIG (a compress on that same edge is NOT included), then → DONE.
  - DONE: result_valid=1 with pass/fail registered, one cycle after finish sampled. Values hold while in DONE. init → ARMED, clearing result_valid/pass/fail on that edge.
- Simultaneous events:
  - init has priority over finish and compress in every state.
  - finish has priority over compress.
- pass and fail are mutually exclusive; both are 0 whenever result_valid=0.
- Outputs are register-driven; no combinational input-to-output paths.

Optional Feature:
- Macro: BIST_SIG_CYCLE_CHECK_EN.
- Defined: pass additionally requires cycle_count==EXPECTED_CYCLES. A signature match with a wrong count gives fail=1.
- Undefined: cycle_count is still output but excluded from pass/fail; EXPECTED_CYCLES is unused.

Decomposition:
- Package bist_pkg holds:
  - default MISR_WIDTH/POLY constants;
  - the checker FSM state enum (IDLE, ARMED, COMPRESS, DONE);
  - a function computing one MISR step.
- Sub-module bist_misr (register + next-state with load/enable inputs) is natural; the FSM, counter and compare live in the top.

Test Plan:
- SEED=0: init, then one compress with scan_out=4'hA → signature 16'h000A. Second compress with 4'h5 → 16'h0011, cycle_count=2.
- SEED=16'h8000: init, one compress with scan_out=0 → signature 16'h1021 (feedback path).
- GOLDEN_SIG=16'h0011, sequence A,5, then finish → result_valid=1 next cycle, pass=1, fail=0. GOLDEN_SIG=16'h0012 → pass=0, fail=1. Next init clears result_valid.
- finish or running pulses without init, after reset → state stays IDLE, result_valid=0, signature=SEED.
- Reset asserted mid-COMPRESS after 3 cycles → next edge signature=SEED, cycle_count=0, outputs 0. A new init plus 2 compresses gives cycle_count=2.
- With BIST_SIG_CYCLE_CHECK_EN, EXPECTED_CYCLES=3, matching signature after 2 cycles → fail=1. After 3 cycles with matching golden → pass=1.
